ch3_wave_core: RTL and testbench
================================

# ch3_wave_core

Channel 3 (wave) playback engine of the APU: the consumer of the channel-3 register file. It takes the latched NR30–NR34 fields, trigger pulse and length-load strobe. It runs the 11-bit frequency timer, 5-bit sample index, wave-RAM fetch, 8-bit length counter and volume shift, and produces the 4-bit channel sample and the channel-active flag. It also drives the inverted frequency-counter value back to the register block for readback.

## Interface

Parameters:
- FREQ_W, 11, frequency timer width
- LEN_W, 8, length counter width

Ports:
- `cery_2mhz`  in  1  2 MiHz APU clock. One clock; all state changes on its rising edge.
- `napu_reset`  in  1  asynchronous, active-low reset.
- `dac_en`  in  1  NR30 bit 7; 0 forces channel inactive.
- `len_wr`  in  1  one-cycle strobe for an NR31 write.
- `len_data`  in  8  NR31 value, valid with `len_wr`.
- `vol_code`  in  2  NR32 bits 6:5.
- `freq`  in  11  {NR34[2:0], NR33[7:0]}.
- `len_en`  in  1  NR34 bit 6.
- `trig`  in  1  one-cycle trigger pulse (NR34 bit 7 write).
- `len_tick`  in  1  one-cycle 256 Hz frame-sequencer tick.
- `wave_addr`  out  4  wave-RAM byte address.
- `wave_rd`  out  1  one-cycle read request.
- `wave_data`  in  8  wave-RAM byte, valid the cycle after `wave_rd`.
- `ch3_out`  out  4  shifted sample; 0 when inactive.
- `ch3_active`  out  1  channel-on flag (NR52 bit 2).
- `nfreq_cnt`  out  11  bitwise inverse of the frequency timer, for readback.

## Operation

- Reset: timer=0, index=0, sample buffer=0, length=0, active=0, `wave_rd`=0, `wave_addr`=0, `ch3_out`=0, `nfreq_cnt`=11'h7FF.
- Frequency timer:
  - Increments every cycle while active.
  - On 0x7FF it reloads `freq` instead of incrementing. That cycle also increments the index mod 32 and asserts `wave_rd` on the next cycle.
  - Period is (2048 − freq) cycles.
- Wave fetch:
  - `wave_addr` = index[4:1].
  - `wave_data` is captured into the 8-bit buffer the cycle after `wave_rd`.
  - Selected nibble: index[0]=0 selects the high nibble; index[0]=1 selects the low nibble.
- Volume on the selected nibble `s`:
  - vol 00 → 0
  - vol 01 → s
  - vol 10 → s>>1
  - vol 11 → s>>2
  - `ch3_out` is registered; it is 0 whenever active=0.
- Length counter:
  - `len_wr` loads `len_data`.
  - Counts up on `len_tick` when `len_en`=1.
  - Wrap 0xFF→0x00 clears active.
  - Length counts even when inactive, but has no further effect.
- Trigger:
  - active ← `dac_en`; timer ← `freq`; index ← 0.
  - Sample buffer is retained; the first fetch happens at the first timer overflow.
  - If length==0, length stays 0, giving the full 256 ticks.
- `dac_en`=0 clears active on the next edge and holds it clear.
- Precedence:
  - `trig` over `len_tick` in the same cycle: the tick is dropped.
  - `len_wr` over `len_tick`.
  - `dac_en`=0 over `trig`: stays inactive.
  - A length wrap coinciding with `trig`: trigger wins.

## Timing

- Trigger at edge N: active=1 and timer=`freq` visible after N.
- Overflow cycle O: index+1 visible after O; `wave_rd` high in O+1; buffer updated at end of O+2; `ch3_out` updated at end of O+3.
- Length wrap: active low one cycle after the `len_tick` edge; `ch3_out`=0 the cycle after.
- `nfreq_cnt` is combinational from the timer register.
- Reset deassertion mid-operation: every register resumes from its reset value with no spurious `wave_rd`.
- `freq`=0x7FF: overflow every cycle. The index advances each cycle and `wave_rd` stays continuously high; this is legal.

## Structure

- Shared package `ch3_pkg` holds:
  - `vol_code_t` enum: MUTE, FULL, HALF, QUARTER
  - constants `CH3_FREQ_W`=11, `CH3_LEN_W`=8, `CH3_IDX_W`=5
  - `CH3_WAVE_BYTES`=16
- One sub-module, `ch3_length_counter`: load/tick/enable in, expire pulse out.
- Timer, index, fetch and volume stay in the top module.

## Test plan

- Reset release, no stimulus → `ch3_out`=0, `ch3_active`=0, `nfreq_cnt`=11'h7FF, `wave_rd` never high.
- `dac_en`=1, `freq`=0x7FE, vol=01, RAM byte0=0xA5, `trig` → `wave_rd` every 2 cycles; `ch3_out` sequence 0x5, 0xA (index 1, index 2, …) with addresses 0, 1, 1, 2, …
- Same setup with vol=10, then 11, sample 0xA → output 0x5, then 0x2; with vol=00 → 0.
- `len_data`=0xFE, `len_en`=1, `trig`, 2 `len_tick`s → active drops one cycle after the second tick. `len_wr` coincident with a tick → loaded value wins.
- `trig` with `dac_en`=0 → active stays 0. `dac_en` 1→0 while playing → active=0 next cycle, `ch3_out`=0 the following cycle.
- `trig` and `len_tick` in the same cycle with length=0xFF → channel active, length still 0xFF. `napu_reset` asserted mid-playback → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/ch3_pkg.sv
// Shared types, widths and volume helper for the channel-3 wave engine.
package ch3_pkg;

  localparam int unsigned CH3_FREQ_W     = 11;
  localparam int unsigned CH3_LEN_W      = 8;
  localparam int unsigned CH3_IDX_W      = 5;
  localparam int unsigned CH3_WAVE_BYTES = 16;

  typedef enum logic [1:0] {
    MUTE    = 2'd0,
    FULL    = 2'd1,
    HALF    = 2'd2,
    QUARTER = 2'd3
  } vol_code_t;

  // NR32 volume: mute, or right shift of the 4-bit sample by 0, 1 or 2.
  function automatic logic [3:0] ch3_vol_shift(input vol_code_t code, input logic [3:0] s);
    logic [3:0] r;
    r = 4'd0;
    case (code)
      MUTE:    r = 4'd0;
      FULL:    r = s;
      HALF:    r = s >> 1;
      QUARTER: r = s >> 2;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ch3_length_counter.sv
// Up-counting length timer; pulses expire when a counted tick wraps the value to zero.
module ch3_length_counter
  import ch3_pkg::*;
#(
  parameter int unsigned LEN_W = CH3_LEN_W
) (
  input  logic             cery_2mhz,
  input  logic             napu_reset,
  input  logic             load,
  input  logic [LEN_W-1:0] load_data,
  input  logic             tick,
  input  logic             en,
  input  logic             hold,
  output logic             expire
);

  logic [LEN_W-1:0] len_q, len_d;
  logic             tick_eff;

  // A load or a trigger in the same cycle swallows the tick.
  always_comb begin
    tick_eff = tick & en & ~load & ~hold;
    expire   = tick_eff & (len_q == {LEN_W{1'b1}});
    len_d    = len_q;
    if (load) begin
      len_d = load_data;
    end else if (tick_eff) begin
      len_d = len_q + 1'b1;
    end
  end

  // Length state register.
  always_ff @(posedge cery_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/ch3_wave_core.sv
// Channel-3 playback: frequency timer, sample index, wave-RAM fetch, volume and active flag.
module ch3_wave_core
  import ch3_pkg::*;
#(
  parameter int unsigned FREQ_W = CH3_FREQ_W,
  parameter int unsigned LEN_W  = CH3_LEN_W
) (
  input  logic              cery_2mhz,
  input  logic              napu_reset,
  input  logic              dac_en,
  input  logic              len_wr,
  input  logic [LEN_W-1:0]  len_data,
  input  logic [1:0]        vol_code,
  input  logic [FREQ_W-1:0] freq,
  input  logic              len_en,
  input  logic              trig,
  input  logic              len_tick,
  output logic [3:0]        wave_addr,
  output logic              wave_rd,
  input  logic [7:0]        wave_data,
  output logic [3:0]        ch3_out,
  output logic              ch3_active,
  output logic [FREQ_W-1:0] nfreq_cnt
);

  logic [FREQ_W-1:0]    timer_q, timer_d;
  logic [CH3_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]           sample_buf_q, sample_buf_d;
  logic                 active_q, active_d;
  logic                 rd_q, rd_d;
  logic                 cap_q, cap_d;
  // Nibble select travels with the fetch so it matches the byte it arrives with.
  logic                 fetch_sel_q, fetch_sel_d;
  logic                 sel_q, sel_d;
  logic [3:0]           out_q, out_d;
  logic                 overflow;
  logic                 len_expire;

  ch3_length_counter #(
    .LEN_W(LEN_W)
  ) u_len (
    .cery_2mhz (cery_2mhz),
    .napu_reset(napu_reset),
    .load      (len_wr),
    .load_data (len_data),
    .tick      (len_tick),
    .en        (len_en),
    .hold      (trig),
    .expire    (len_expire)
  );

  // Next-state logic for timer, index, fetch pipeline, active flag and output sample.
  always_comb begin
    overflow     = active_q & (timer_q == {FREQ_W{1'b1}});
    timer_d      = timer_q;
    idx_d        = idx_q;
    if (trig) begin
      timer_d = freq;
      idx_d   = '0;
    end else if (overflow) begin
      timer_d = freq;
      idx_d   = idx_q + 1'b1;
    end else if (active_q) begin
      timer_d = timer_q + 1'b1;
    end

    rd_d         = overflow & ~trig;
    cap_d        = rd_q;
    fetch_sel_d  = rd_q ? idx_q[0] : fetch_sel_q;
    sel_d        = cap_q ? fetch_sel_q : sel_q;
    sample_buf_d = cap_q ? wave_data : sample_buf_q;

    if (!dac_en) begin
      active_d = 1'b0;
    end else if (trig) begin
      active_d = 1'b1;
    end else if (len_expire) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end

    out_d = 4'd0;
    if (active_q) begin
      out_d = ch3_vol_shift(vol_code_t'(vol_code),
                            sel_q ? sample_buf_q[3:0] : sample_buf_q[7:4]);
    end
  end

  // Channel state registers.
  always_ff @(posedge cery_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      timer_q      <= '0;
      idx_q        <= '0;
      sample_buf_q <= '0;
      active_q     <= 1'b0;
      rd_q         <= 1'b0;
      cap_q        <= 1'b0;
      fetch_sel_q  <= 1'b0;
      sel_q        <= 1'b0;
      out_q        <= '0;
    end else begin
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      sample_buf_q <= sample_buf_d;
      active_q     <= active_d;
      rd_q         <= rd_d;
      cap_q        <= cap_d;
      fetch_sel_q  <= fetch_sel_d;
      sel_q        <= sel_d;
      out_q        <= out_d;
    end
  end

  assign wave_addr  = idx_q[CH3_IDX_W-1:1];
  assign wave_rd    = rd_q;
  assign ch3_out    = out_q;
  assign ch3_active = active_q;
  assign nfreq_cnt  = ~timer_q;

endmodule

// File: tb/tb_ch3_wave_core.sv
// Scoreboard bench for ch3_wave_core: expected fetch address/sample pairs are queued at
// trigger time and a negedge monitor retires them against wave_rd and ch3_out.
module tb_ch3_wave_core;

  logic        cery_2mhz = 1'b0;
  logic        napu_reset = 1'b1;
  logic        dac_en = 1'b0;
  logic        len_wr = 1'b0;
  logic [7:0]  len_data = 8'h00;
  logic [1:0]  vol_code = 2'b01;
  logic [10:0] freq = 11'h000;
  logic        len_en = 1'b0;
  logic        trig = 1'b0;
  logic        len_tick = 1'b0;
  logic [3:0]  wave_addr;
  logic        wave_rd;
  logic [7:0]  wave_data = 8'h00;
  logic [3:0]  ch3_out;
  logic        ch3_active;
  logic [10:0] nfreq_cnt;

  always #5 cery_2mhz = ~cery_2mhz;

  ch3_wave_core #(
    .FREQ_W(11),
    .LEN_W (8)
  ) dut (
    .cery_2mhz (cery_2mhz),
    .napu_reset(napu_reset),
    .dac_en    (dac_en),
    .len_wr    (len_wr),
    .len_data  (len_data),
    .vol_code  (vol_code),
    .freq      (freq),
    .len_en    (len_en),
    .trig      (trig),
    .len_tick  (len_tick),
    .wave_addr (wave_addr),
    .wave_rd   (wave_rd),
    .wave_data (wave_data),
    .ch3_out   (ch3_out),
    .ch3_active(ch3_active),
    .nfreq_cnt (nfreq_cnt)
  );

  // Wave RAM: byte returned the cycle after the read request.
  logic [7:0] ram [16];
  initial begin
    forever begin
      @(posedge cery_2mhz);
      if (wave_rd === 1'b1) wave_data <= ram[wave_addr];
    end
  end

  typedef struct {
    logic [3:0] addr;
    logic [3:0] sample;
  } exp_t;
  typedef struct {
    logic [3:0] sample;
    int         due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    cyc_n = 0;
  int    rd_seen = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each wave_rd retires one expected address; its sample shows on ch3_out 3 cycles on.
  exp_t  mon_e;
  pend_t mon_p;
  initial begin
    forever begin
      @(negedge cery_2mhz);
      cyc_n++;
      if (wave_rd === 1'b1) begin
        rd_seen++;
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("wave_addr", {28'd0, wave_addr}, {28'd0, mon_e.addr});
          mon_p.sample = mon_e.sample;
          mon_p.due    = cyc_n + 3;
          pend_q.push_back(mon_p);
        end
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc_n) begin
        mon_p = pend_q.pop_front();
        check("ch3_out", {28'd0, ch3_out}, {28'd0, mon_p.sample});
      end
    end
  end

  task automatic step();
    @(posedge cery_2mhz);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] s);
    exp_t e;
    e.addr   = a;
    e.sample = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pend_q.size() > 0) && n < 300) begin
      step();
      n++;
    end
    check({tag, " drain"}, exp_q.size() + pend_q.size(), 0);
  endtask

  // Trigger playback and queue five fetches (indices 1..5 -> addresses 0,1,1,2,2).
  task automatic play(input string tag, input logic [10:0] f, input logic [1:0] v,
                      input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2,
                      input logic [3:0] e3, input logic [3:0] e4);
    freq     = f;
    vol_code = v;
    dac_en   = 1'b1;
    step();
    push_exp(4'd0, e0);
    push_exp(4'd1, e1);
    push_exp(4'd1, e2);
    push_exp(4'd2, e3);
    push_exp(4'd2, e4);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check({tag, " active"}, {31'd0, ch3_active}, 1);
    check({tag, " nfreq"}, {21'd0, nfreq_cnt}, {21'd0, ~f});
    wait_drain(tag);
  endtask

  // Drop the DAC: active clears next edge, output clears the edge after.
  task automatic stop(input string tag);
    dac_en = 1'b0;
    step();
    check({tag, " dac off active"}, {31'd0, ch3_active}, 0);
    step();
    check({tag, " dac off out"}, {28'd0, ch3_out}, 0);
    repeat (4) step();
  endtask

  task automatic tick_once();
    len_tick = 1'b1;
    step();
    len_tick = 1'b0;
  endtask

  task automatic load_len(input logic [7:0] d);
    len_wr   = 1'b1;
    len_data = d;
    step();
    len_wr   = 1'b0;
  endtask

  initial begin
    int rd_base;
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int rd_base;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'hA5;
    ram[1] = 8'hA7;
    ram[2] = 8'h1E;

    #2 napu_reset = 1'b0;
    #3;
    check("reset nfreq", {21'd0, nfreq_cnt}, 32'h7FF);
    repeat (3) step();
    napu_reset = 1'b1;
    repeat (20) step();
    check("idle out", {28'd0, ch3_out}, 0);
    check("idle active", {31'd0, ch3_active}, 0);
    check("idle nfreq", {21'd0, nfreq_cnt}, 32'h7FF);
    check("idle addr", {28'd0, wave_addr}, 0);
    check("idle rd count", rd_seen, 0);

    // Samples: idx1=A5.lo, idx2=A7.hi, idx3=A7.lo, idx4=1E.hi, idx5=1E.lo.
    play("full 7FE", 11'h7FE, 2'b01, 4'h5, 4'hA, 4'h7, 4'h1, 4'hE);
    stop("full 7FE");
    play("half", 11'h7FE, 2'b10, 4'h2, 4'h5, 4'h3, 4'h0, 4'h7);
    stop("half");
    play("quarter", 11'h7FE, 2'b11, 4'h1, 4'h2, 4'h1, 4'h0, 4'h3);
    stop("quarter");
    play("mute", 11'h7FE, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    stop("mute");
    play("full 7F0", 11'h7F0, 2'b01, 4'h5, 4'hA, 4'h7, 4'h1, 4'hE);
    stop("full 7F0");
    play("full 7FF", 11'h7FF, 2'b01, 4'h5, 4'hA, 4'h7, 4'h1, 4'hE);
    stop("full 7FF");

    // Length expiry from FE after two ticks.
    freq   = 11'h000;
    dac_en = 1'b1;
    len_en = 1'b1;
    load_len(8'hFE);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("len trig active", {31'd0, ch3_active}, 1);
    tick_once();
    check("len tick1 active", {31'd0, ch3_active}, 1);
    tick_once();
    check("len wrap active", {31'd0, ch3_active}, 0);
    step();
    check("len wrap out", {28'd0, ch3_out}, 0);

    // Load coincident with a tick at FF: loaded FD wins, three more ticks to expire.
    load_len(8'hFF);
    trig = 1'b1;
    step();
    trig = 1'b0;
    len_wr   = 1'b1;
    len_data = 8'hFD;
    len_tick = 1'b1;
    step();
    len_wr   = 1'b0;
    len_tick = 1'b0;
    check("len load vs tick", {31'd0, ch3_active}, 1);
    tick_once();
    tick_once();
    check("len FD two ticks", {31'd0, ch3_active}, 1);
    tick_once();
    check("len FD expire", {31'd0, ch3_active}, 0);

    // Trigger and tick together at FF: tick dropped, one more tick expires.
    load_len(8'hFF);
    trig     = 1'b1;
    len_tick = 1'b1;
    step();
    trig     = 1'b0;
    len_tick = 1'b0;
    check("trig+tick active", {31'd0, ch3_active}, 1);
    tick_once();
    check("trig+tick held FF", {31'd0, ch3_active}, 0);
    len_en = 1'b0;

    // Trigger with DAC off stays inactive.
    dac_en = 1'b0;
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("trig dac off", {31'd0, ch3_active}, 0);

    // Asynchronous reset during playback.
    freq     = 11'h7FE;
    vol_code = 2'b01;
    dac_en   = 1'b1;
    trig     = 1'b1;
    step();
    trig = 1'b0;
    repeat (10) step();
    #2 napu_reset = 1'b0;
    #1;
    check("areset out", {28'd0, ch3_out}, 0);
    check("areset active", {31'd0, ch3_active}, 0);
    check("areset nfreq", {21'd0, nfreq_cnt}, 32'h7FF);
    check("areset rd", {31'd0, wave_rd}, 0);
    check("areset addr", {28'd0, wave_addr}, 0);
    repeat (3) step();
    rd_base    = rd_seen;
    napu_reset = 1'b1;
    repeat (20) step();
    check("post reset rd count", rd_seen - rd_base, 0);
    check("post reset active", {31'd0, ch3_active}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
